// File: rtl/alu_iter_if.sv
// Operand/result bundle between the ISDU/regfile side and the execute-stage ALU.
interface alu_iter_if #(
   parameter int WIDTH = 16
);
   logic             i_start;
   logic [2:0]       i_aluk;
   logic [WIDTH-1:0] i_sr1out;
   logic [WIDTH-1:0] i_sr2out;
   logic             i_ir5;
   logic [4:0]       i_imm5;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_alu_out;
   logic [2:0]       o_nzp;

   modport master (
      output i_start, i_aluk, i_sr1out, i_sr2out, i_ir5, i_imm5,
      input  o_busy, o_done, o_alu_out, o_nzp
   );

   modport slave (
      input  i_start, i_aluk, i_sr1out, i_sr2out, i_ir5, i_imm5,
      output o_busy, o_done, o_alu_out, o_nzp
   );
endinterface

// File: rtl/alu_iter.sv
// Execute-stage ALU (ADD/AND/NOT/PASSA) with start/done handshake and registered result + NZP.
// Define ALU_MUL_EN to make ALUK=100 an iterative shift-add MUL; otherwise it behaves as PASSA.
module alu_iter #(
   parameter int WIDTH   = 16,
   parameter int MUL_CYC = 16
) (
   input logic       i_clk,
   input logic       i_rst_n,
   alu_iter_if.slave bus
);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_MULT} state_t;
   localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_mul_step;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

   if (MUL_CYC != WIDTH) begin : g_cfg_check
      $error("alu_iter: MUL_CYC must equal WIDTH");
   end

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_aluk;
   logic [WIDTH-1:0] r_out;
   logic [2:0]       r_nzp;
   logic             w_accept;
   logic             w_res_we;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_wr_val;
   logic [2:0]       w_nzp;

   assign w_accept = bus.i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_opb    = bus.i_ir5 ? {{(WIDTH-5){bus.i_imm5[4]}}, bus.i_imm5} : bus.i_sr2out;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // DONE doubles as an accept slot so a held Start chains ops without an IDLE gap.
   always_comb begin
      w_next   = r_state;
      w_res_we = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
`ifdef ALU_MUL_EN
               w_next = (bus.i_aluk == 3'b100) ? S_MULT : S_EXEC;
`else
               w_next = S_EXEC;
`endif
            end else begin
               w_next = S_IDLE;
            end
         end
         S_EXEC: begin
            w_next   = S_DONE;
            w_res_we = 1'b1;
         end
`ifdef ALU_MUL_EN
         S_MULT: begin
            if (r_cnt == CW'(MUL_CYC - 1)) begin
               w_next   = S_DONE;
               w_res_we = 1'b1;
            end
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_aluk)
         3'b000:  w_alu = r_a + r_b;
         3'b001:  w_alu = r_a & r_b;
         3'b010:  w_alu = ~r_a;
         default: w_alu = r_a;
      endcase
      w_wr_val = w_alu;
`ifdef ALU_MUL_EN
      // r_a is the left-shifting multiplicand, r_b the right-shifting multiplier.
      w_mul_step = r_acc + (r_b[0] ? r_a : '0);
      if (r_state == S_MULT) w_wr_val = w_mul_step;
`endif
      w_nzp = {w_wr_val[WIDTH-1],
               (w_wr_val == '0),
               (!w_wr_val[WIDTH-1] && (w_wr_val != '0))};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_aluk <= 3'b000;
         r_out  <= '0;
         r_nzp  <= 3'b000;
`ifdef ALU_MUL_EN
         r_acc  <= '0;
         r_cnt  <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_a    <= bus.i_sr1out;
            r_b    <= w_opb;
            r_aluk <= bus.i_aluk;
`ifdef ALU_MUL_EN
            r_acc  <= '0;
            r_cnt  <= '0;
`endif
         end
`ifdef ALU_MUL_EN
         else if (r_state == S_MULT) begin
            r_acc <= w_mul_step;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
         end
`endif
         if (w_res_we) begin
            r_out <= w_wr_val;
            r_nzp <= w_nzp;
         end
      end
   end

`ifdef ALU_MUL_EN
   assign bus.o_busy = (r_state == S_EXEC) || (r_state == S_MULT);
`else
   assign bus.o_busy = (r_state == S_EXEC);
`endif
   assign bus.o_done    = (r_state == S_DONE);
   assign bus.o_alu_out = r_out;
   assign bus.o_nzp     = r_nzp;

endmodule
